// File: rtl/reg32_reader.sv
// reg32_reader: captures a register word and streams it out as hex digits, MSB first, over a valid/ready handshake (optional READER_ZERO_BLANK_EN skips leading zero digits)
module reg32_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic             busy,
  output logic [3:0]       nib_out,
  output logic [2:0]       nib_idx,
  output logic             nib_valid,
  input  logic             nib_ready,
  output logic             nib_last,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam int N = WIDTH / 4;
  localparam logic [2:0] TOP = 3'(N - 1);
  state_t state;
  logic [WIDTH-1:0] shadow;
  logic [2:0] first;
  function automatic logic [3:0] nib(input logic [WIDTH-1:0] w, input logic [2:0] i);
    return 4'(w >> {i, 2'b00});
  endfunction
  // index of the first digit to present for the word being captured
  always_comb begin
    first = TOP;
`ifdef READER_ZERO_BLANK_EN
    first = '0;
    for (int i = 0; i < N; i++)
      if (nib(data_in, 3'(i)) != 4'h0) first = 3'(i);
`endif
  end
  // readout sequencer with registered handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      busy      <= 1'b0;
      nib_valid <= 1'b0;
      nib_last  <= 1'b0;
      nib_out   <= '0;
      nib_idx   <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shadow    <= data_in;
          state     <= SEND;
          busy      <= 1'b1;
          nib_valid <= 1'b1;
          nib_idx   <= first;
          nib_out   <= nib(data_in, first);
          nib_last  <= first == 3'd0;
        end
        SEND: if (nib_ready) begin
          if (nib_last) begin
            state     <= DONE;
            nib_valid <= 1'b0;
            nib_last  <= 1'b0;
            done      <= 1'b1;
          end else begin
            nib_idx  <= nib_idx - 3'd1;
            nib_out  <= nib(shadow, nib_idx - 3'd1);
            nib_last <= nib_idx == 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
